fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have parameter BURST_MAX, default 4, setting the maximum beats per grant (legal range 1..15).
REQ-002 The block SHALL have port ck, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port Req0, input, 1 bit: producer 0 has a byte to write.
REQ-005 The block SHALL have port Din0, input, 8 bits: producer 0 data, valid while Req0=1.
REQ-006 The block SHALL have port Req1, input, 1 bit: producer 1 has a byte to write.
REQ-007 The block SHALL have port Din1, input, 8 bits: producer 1 data, valid while Req1=1.
REQ-008 The block SHALL have port Ffull, input, 1 bit: full flag from the downstream 16x8 FIFO.
REQ-009 The block SHALL have port Wen, output, 1 bit: FIFO write enable.
REQ-010 The block SHALL have port Dout, output, 8 bits: FIFO write data (drives FIFO Din).
REQ-011 The block SHALL have ports Ack0 and Ack1, outputs, 1 bit each: the byte of producer 0 or 1 is written this cycle.
REQ-012 The block SHALL have port Grant, output, 2 bits: current owner, 00 idle, 01 producer 0, 10 producer 1.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, G0 and G1, a 4-bit beat counter cnt, and a 1-bit last-served flag Last.
REQ-014 The block SHALL derive Wen, Dout, Ack0 and Ack1 combinationally in the same cycle: Wen=(G0&Req0|G1&Req1)&!Ffull; Dout=Din of owner (00 when IDLE); Ackx=Wen&(state==Gx).
REQ-015 A beat SHALL be any cycle with Wen=1; a byte SHALL never be written while Ffull=1, and every Ack SHALL coincide with exactly one FIFO write.
REQ-016 In IDLE with any Req set, the FSM SHALL move to G0 or G1 at the next edge, selecting the only requester or, if both request, per arbitration policy (REQ-025); cnt is cleared; this gives 1 cycle arbitration latency and Wen=0 while in IDLE.
REQ-017 In Gx, each beat SHALL increment cnt; a stall (Reqx=1, Ffull=1) SHALL hold state and cnt indefinitely with no timeout.
REQ-018 In Gx with Reqx=0, the FSM SHALL move at the next edge to Gy if Reqy=1, else to IDLE; Last is set to x and cnt is cleared.
REQ-019 In Gx, a beat that brings cnt to BURST_MAX SHALL hand the grant to Gy if Reqy=1 (Last=x, cnt=0); otherwise the FSM SHALL stay in Gx with cnt cleared.
REQ-020 Handover between G0 and G1 SHALL take zero idle states; the new owner may write on the first cycle after the switch edge.
REQ-021 Grant SHALL reflect the registered state only and SHALL never be 11.
REQ-022 Req/Din changes of the non-owner SHALL have no effect on Wen or Dout.

Reset
REQ-023 When rst=0, the block SHALL immediately force state=IDLE, cnt=0, Last=1; consequently Wen=0, Ack0=Ack1=0, Grant=00 and Dout=00, without waiting for a clock edge.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no write in that cycle, and the first arbitration after release SHALL favour producer 0.

Configuration
REQ-025 With FIFO_WR_ARB_FIXED_PRIO_EN undefined, the block SHALL use round-robin arbitration: on a tie the grant goes to the producer other than Last.
REQ-026 With FIFO_WR_ARB_FIXED_PRIO_EN defined, a tie SHALL always grant producer 0, and REQ-019 handover SHALL occur only from G1 to G0; G0 keeps its grant (cnt cleared) while Req0=1.

Verification
REQ-027 The bench SHALL cover: reset, then Req0=Req1=1 held with Din0=A0, Din1=B1 and Ffull=0 -> IDLE for 1 cycle, then 4 writes of A0 (Ack0), then 4 writes of B1 (Ack1), alternating; with the macro defined, A0 writes continuously.
REQ-028 The bench SHALL cover: Req0=1 only, 10 cycles -> Grant=01 throughout after 1 cycle, 9 writes, and cnt wraps at 4 without leaving G0.
REQ-029 The bench SHALL cover: G1 with Ffull=1 for 5 cycles mid-burst -> Wen=0 and Ack1=0 for those 5 cycles, with the burst resuming at the same cnt afterwards.
REQ-030 The bench SHALL cover: 16 writes into an empty FIFO model, then continued Req0=1 -> Wen drops as Ffull rises and no byte is lost or duplicated (scoreboard compares FIFO contents against the Ack'd bytes).
REQ-031 The bench SHALL cover: rst pulsed low between edges during the 2nd beat of a G1 burst -> Wen=0 and Grant=00 immediately, and after release with both requesting, G0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb -- two-producer write arbiter in front of a 16x8 FIFO.
//
// Producers 0 and 1 each present one byte at a time (ReqX/DinX). The arbiter
// grants one producer at a time and streams its bytes into the FIFO. A grant
// lasts at most BURST_MAX beats while the other producer is waiting. Writes are
// held off (stalled, not dropped) while the FIFO reports full.
//
// Parameters
//   BURST_MAX   maximum beats per grant, 1..15
//
// Ports
//   ck          clock, all state updates on rising edge
//   rst         asynchronous active-low reset
//   Req0/Din0   producer 0 request and byte
//   Req1/Din1   producer 1 request and byte
//   Ffull       downstream FIFO full flag
//   Wen/Dout    FIFO write enable and write data
//   Ack0/Ack1   producer's byte is written this cycle
//   Grant       registered owner: 00 idle, 01 producer 0, 10 producer 1
//
// Build option
//   FIFO_WR_ARB_FIXED_PRIO_EN  defined: producer 0 wins ties and is never
//   pre-empted at burst end; undefined (default): round-robin on ties and
//   handover at burst end in both directions.
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int BURST_MAX = 4
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       Req0,
    input  logic [7:0] Din0,
    input  logic       Req1,
    input  logic [7:0] Din1,
    input  logic       Ffull,
    output logic       Wen,
    output logic [7:0] Dout,
    output logic       Ack0,
    output logic       Ack1,
    output logic [1:0] Grant
);

    // Encoding doubles as the Grant value, so 2'b11 is unreachable.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    // cnt == CNT_LAST on a beat means this beat completes the burst.
    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       last, last_nx;   // producer that most recently gave up a grant
    logic       owner_req;
    state_t     tie_pick;
    logic       handover_g0;     // G0 may yield to a waiting producer 1 at burst end
    logic       handover_g1;

`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    assign tie_pick    = G0;
    assign handover_g0 = 1'b0;
    assign handover_g1 = 1'b1;
`else
    assign tie_pick    = last ? G0 : G1;
    assign handover_g0 = 1'b1;
    assign handover_g1 = 1'b1;
`endif

    // Write path: purely combinational from the registered owner, so a
    // non-owner's Req/Din can never reach Wen or Dout.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        owner_req = 1'b0;
        Dout      = 8'h00;
        case (state)
            G0: begin
                owner_req = Req0;
                Dout      = Din0;
            end
            G1: begin
                owner_req = Req1;
                Dout      = Din1;
            end
            default: ;
        endcase
    end

    assign Wen   = owner_req & ~Ffull;
    assign Ack0  = Wen & (state == G0);
    assign Ack1  = Wen & (state == G1);
    assign Grant = state;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        case (state)
            IDLE: begin
                cnt_nx = 4'd0;
                if (Req0 && Req1) state_nx = tie_pick;
                else if (Req0)    state_nx = G0;
                else if (Req1)    state_nx = G1;
            end
            G0: begin
                if (!Req0) begin
                    last_nx  = 1'b0;
                    cnt_nx   = 4'd0;
                    state_nx = Req1 ? G1 : IDLE;
                end else if (Wen) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx = 4'd0;
                        if (Req1 && handover_g0) begin
                            state_nx = G1;
                            last_nx  = 1'b0;
                        end
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
                // Req0 with Ffull: stall, hold state and cnt.
            end
            G1: begin
                if (!Req1) begin
                    last_nx  = 1'b1;
                    cnt_nx   = 4'd0;
                    state_nx = Req0 ? G0 : IDLE;
                end else if (Wen) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx = 4'd0;
                        if (Req0 && handover_g1) begin
                            state_nx = G0;
                            last_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Last resets to 1 so the first tie after reset goes to producer 0.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            last  <= 1'b1;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values regardless of block order.
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb -- self-checking bench for fifo_wr_arb.
// A behavioural owner/beat model predicts the outputs every cycle; directed
// scenarios add literal expectations, and a FIFO model with a scoreboard checks
// that the bytes written equal the bytes acknowledged.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

    localparam int BURST_MAX = 4;
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       ck = 1'b0;
    logic       rst;
    logic       Req0, Req1, Ffull;
    logic [7:0] Din0, Din1;
    logic       Wen, Ack0, Ack1;
    logic [7:0] Dout;
    logic [1:0] Grant;

    always #5 ck = ~ck;

    fifo_wr_arb #(.BURST_MAX(BURST_MAX)) dut (
        .ck   (ck),
        .rst  (rst),
        .Req0 (Req0),
        .Din0 (Din0),
        .Req1 (Req1),
        .Din1 (Din1),
        .Ffull(Ffull),
        .Wen  (Wen),
        .Dout (Dout),
        .Ack0 (Ack0),
        .Ack1 (Ack1),
        .Grant(Grant)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 idle, 0 or 1 the granted producer; beats: beats in this burst.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = 1;
    int m_p, m_q;

    function automatic bit m_req(int p);
        return (p == 0) ? Req0 : Req1;
    endfunction

    function automatic logic [7:0] m_din(int p);
        return (p == 0) ? Din0 : Din1;
    endfunction

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = 1;
        end else if (m_owner < 0) begin
            if (Req0 && Req1) m_owner = FIXED ? 0 : 1 - m_last;
            else if (Req0)    m_owner = 0;
            else if (Req1)    m_owner = 1;
            m_beats = 0;
        end else begin
            m_p = m_owner;
            m_q = 1 - m_owner;
            if (!m_req(m_p)) begin
                m_last  = m_p;
                m_beats = 0;
                m_owner = m_req(m_q) ? m_q : -1;
            end else if (!Ffull) begin
                m_beats = m_beats + 1;
                if (m_beats == BURST_MAX) begin
                    m_beats = 0;
                    if (m_req(m_q) && (!FIXED || m_p == 1)) begin
                        m_last  = m_p;
                        m_owner = m_q;
                    end
                end
            end
        end
    end

    // ---------------- compare process + FIFO model ----------------
    bit         fifo_mode = 1'b0;
    bit         ack0_seen = 1'b0;
    logic [7:0] fifo_q[$];
    logic [7:0] ack_q[$];
    logic       exp_wen;
    logic [7:0] exp_dout;
    logic [1:0] exp_grant;

    always @(negedge ck) begin
        exp_wen   = (m_owner >= 0) && m_req(m_owner) && !Ffull;
        exp_dout  = (m_owner >= 0) ? m_din(m_owner) : 8'h00;
        exp_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        check("model_wen",   Wen,   exp_wen);
        check("model_dout",  Dout,  exp_dout);
        check("model_ack0",  Ack0,  exp_wen && m_owner == 0);
        check("model_ack1",  Ack1,  exp_wen && m_owner == 1);
        check("model_grant", Grant, exp_grant);
        ack0_seen = Ack0;
        if (fifo_mode) begin
            if (Wen)  fifo_q.push_back(Dout);
            if (Ack0) ack_q.push_back(Din0);
            if (Ack1) ack_q.push_back(Din1);
        end
    end

    task automatic cyc();
        @(posedge ck);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    int         seg, nw;
    logic [31:0] got;

    initial begin
        rst = 1'b0; Req0 = 1'b0; Req1 = 1'b0; Ffull = 1'b0;
        Din0 = 8'h00; Din1 = 8'h00;

        // Reset holds outputs quiet even with both producers requesting.
        Req0 = 1'b1; Din0 = 8'hA0;
        Req1 = 1'b1; Din1 = 8'hB1;
        #3;
        check("rst_wen",   Wen,   1'b0);
        check("rst_grant", Grant, 2'b00);
        check("rst_dout",  Dout,  8'h00);
        check("rst_ack",   {Ack0, Ack1}, 2'b00);

        // Both requesting: one idle cycle, then alternating 4-beat bursts.
        @(posedge ck);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 17; k++) begin
            if (k == 0) begin
                check("tie_idle_wen",   Wen,   1'b0);
                check("tie_idle_grant", Grant, 2'b00);
            end else begin
                seg = FIXED ? 0 : ((k - 1) / 4) % 2;
                check("tie_grant", Grant, seg ? 2'b10 : 2'b01);
                check("tie_dout",  Dout,  seg ? 8'hB1 : 8'hA0);
                check("tie_acks",  {Ack0, Ack1}, seg ? 2'b01 : 2'b10);
            end
            cyc();
        end

        // Single requester: stays in G0 across burst-length wraps.
        Req0 = 1'b0; Req1 = 1'b0;
        cyc();
        Req0 = 1'b1; Din0 = 8'h5A;
        nw = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k == 0) check("solo_idle_grant", Grant, 2'b00);
            else        check("solo_grant", Grant, 2'b01);
            if (Wen) nw++;
            cyc();
        end
        check("solo_writes", nw, 9);

        // G1 burst stalled by Ffull for 5 cycles after 2 beats, then resumes.
        Req0 = 1'b0; Req1 = 1'b1; Din1 = 8'hC3;
        #1 check("sw_release_wen", Wen, 1'b0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            check("g1_beat_wen",   Wen,   1'b1);
            check("g1_beat_grant", Grant, 2'b10);
            cyc();
        end
        Ffull = 1'b1; Req0 = 1'b1; Din0 = 8'h77;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_wen",   Wen,   1'b0);
            check("stall_ack1",  Ack1,  1'b0);
            check("stall_grant", Grant, 2'b10);
            check("stall_dout",  Dout,  8'hC3);
            cyc();
        end
        Ffull = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("resume_wen",   Wen,   1'b1);
            check("resume_grant", Grant, 2'b10);
            cyc();
        end
        check("resume_handover_grant", Grant, 2'b01);
        check("resume_handover_dout",  Dout,  8'h77);

        // Fill a 16-deep FIFO model from producer 0 and keep requesting.
        Req0 = 1'b0; Req1 = 1'b0;
        cyc();
        fifo_q.delete();
        ack_q.delete();
        fifo_mode = 1'b1;
        Din0 = 8'h40; Req0 = 1'b1;
        for (int k = 0; k < 24; k++) begin
            cyc();
            if (ack0_seen) Din0 = Din0 + 8'h01;
            Ffull = (fifo_q.size() >= 16);
        end
        #1;
        check("fill_wen_when_full", Wen, 1'b0);
        check("fill_fifo_size",     fifo_q.size(), 16);
        check("fill_ack_size",      ack_q.size(),  16);
        check("fill_pending_byte",  Din0, 8'h50);
        for (int i = 0; i < 16; i++) begin
            got = (i < fifo_q.size()) ? {24'h0, fifo_q[i]} : 32'hFFFF_FFFF;
            check("fill_fifo_byte", got, 32'h40 + i);
            if (i < ack_q.size()) check("fill_fifo_vs_ack", got, {24'h0, ack_q[i]});
        end
        fifo_mode = 1'b0;

        // Reset pulsed between edges during the 2nd beat of a G1 burst.
        Ffull = 1'b0; Req0 = 1'b0; Req1 = 1'b1; Din1 = 8'hD4;
        cyc();
        check("pre_rst_beat1_grant", Grant, 2'b10);
        cyc();
        check("pre_rst_beat2_wen", Wen, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("midrst_wen",   Wen,   1'b0);
        check("midrst_grant", Grant, 2'b00);
        check("midrst_ack1",  Ack1,  1'b0);
        check("midrst_dout",  Dout,  8'h00);
        #3;
        Req0 = 1'b1; Din0 = 8'h61;
        rst  = 1'b1;
        #1 check("post_rst_idle_grant", Grant, 2'b00);
        cyc();
        check("post_rst_first_grant", Grant, 2'b01);
        check("post_rst_ack0",        Ack0,  1'b1);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
